seq_detect_ctrl: RTL and testbench

- Programmable serial pattern-detection controller.
- Owns a shift-register window over a serial bit stream and is configured over a valid/ready handshake with pattern, length, overlap mode and match target.
- Sequences the window through arm, run and done, counts matches, and reports a registered hit.
- Sits between the stimulus/bit source and any downstream logic that counts or reacts to frame-sync patterns.

---
 rtl/seq_detect_pkg.sv | 26 ++
 rtl/seq_window_match.sv | 65 ++++++
 rtl/seq_detect_ctrl.sv | 116 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern-detection controller.
// Holds the FSM state encoding, default sizing and the length clamp.
package seq_detect_pkg;

    localparam int unsigned DefMaxLen = 8;
    localparam int unsigned DefCntW   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Zero-length patterns behave as length 1; oversize lengths saturate.
    function automatic logic [31:0] len_clamp(input logic [31:0] len,
                                              input int unsigned max_len);
        if (len == 32'd0) begin
            return 32'd1;
        end else if (len > 32'(max_len)) begin
            return 32'(max_len);
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_window_match.sv
// Serial bit window with a fill counter and a masked compare of the
// next window value against the low len bits of the pattern.
module seq_window_match #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               x,
    input  logic               clr_fill,
    input  logic               fill_rst_on_match,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match_next
);

    logic [MAX_LEN-1:0] window_q;
    logic [MAX_LEN-1:0] window_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W:0]     fill_inc;
    logic               filled;

    assign window_next = {window_q[MAX_LEN-2:0], x};
    assign fill_inc    = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    assign filled      = fill_inc >= {1'b0, len};

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = i < 32'(len);
        end
    end

    assign match_next = shift_en && filled && ((window_next & mask) == (pattern & mask));

    always_comb begin
        fill_d = fill_q;
        if (clr_fill) begin
            fill_d = '0;
        end else if (shift_en) begin
            if (match_next && fill_rst_on_match) begin
                fill_d = '0;
            end else if (filled) begin
                fill_d = len;
            end else begin
                fill_d = fill_inc[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            fill_q <= fill_d;
            if (shift_en) begin
                window_q <= window_next;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: config handshake, IDLE/RUN/DONE
// sequencing, saturating match counter and a registered hit pulse.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = DefMaxLen,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               x_valid,
    input  logic               x,
    output logic               hit,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               hit_q, hit_d;
    logic               done_q, done_d;
    logic               cfg_acc;
    logic               start_go;
    logic               shift_en;
    logic               match_next;

    assign cfg_ready = state_q != StRun;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign start_go  = start && !abort;
    // A start in RUN restarts cleanly, so the bit offered that cycle is dropped.
    assign shift_en  = (state_q == StRun) && x_valid && !start && !abort;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    seq_window_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk               (clk),
        .rst               (rst),
        .shift_en          (shift_en),
        .x                 (x),
        .clr_fill          (start_go),
        .fill_rst_on_match (!overlap_q),
        .pattern           (pattern_q),
        .len               (len_q),
        .match_next        (match_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        done_d  = done_q;
        if (cfg_acc) begin
            done_d = 1'b0;
        end
        if (abort) begin
            state_d = StIdle;
        end else if (start) begin
            state_d = StRun;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (match_next) begin
            hit_d = 1'b1;
            cnt_d = cnt_inc;
            if ((target_q != '0) && (cnt_inc == target_q)) begin
                state_d = StDone;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
            overlap_q <= 1'b0;
            target_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
            if (cfg_acc) begin
                pattern_q <= cfg_pattern;
                len_q     <= LEN_W'(len_clamp(32'(cfg_len), MAX_LEN));
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
            end
        end
    end

    assign hit       = hit_q;
    assign match_cnt = cnt_q;
    assign busy      = state_q == StRun;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus queues expected hits,
// a negedge monitor pops and checks them whenever hit is seen.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       x_valid;
    logic       x;
    logic       hit;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] cnt;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    seq_detect_ctrl #(
        .MAX_LEN (8),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .hit         (hit),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed hit must match the oldest queued expectation.
    always @(negedge clk) begin
        if (hit === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: got hit cnt=%0d expected no hit at %0t",
                         match_cnt, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hit_cnt", 32'(match_cnt), 32'(e.cnt));
                check("hit_done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                          input logic [7:0] tgt, input logic with_start);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_target  = tgt;
        start       = with_start;
        cycle();
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    // Streams n bits, oldest is bits[n-1]; hits marks bits that complete a match.
    task automatic stream(input logic [7:0] bits, input int n, input logic [7:0] hits,
                          input int cnt0, input int tgt);
        int cnt;
        exp_t e;
        cnt = cnt0;
        for (int i = n - 1; i >= 0; i--) begin
            x       = bits[i];
            x_valid = 1'b1;
            if (hits[i]) begin
                cnt++;
                e.cnt  = 8'(cnt);
                e.done = (tgt != 0) && (cnt == tgt);
                sb_q.push_back(e);
            end
            cycle();
        end
    endtask

    task automatic idle();
        x_valid = 1'b0;
        cycle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;
        start = 0; abort = 0; x_valid = 0; x = 0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Overlap: 1,0,0,1,0,0,1,0 hits on bits 5 and 8.
        do_cfg(8'b10010, 4'd5, 1'b1, 8'd0, 1'b0);
        pulse_start();
        stream(8'b10010010, 8, 8'b00001001, 0, 0);
        idle();
        check("ovl_cnt", 32'(match_cnt), 32'd2);
        check("ovl_busy", 32'(busy), 32'd1);
        pulse_abort();

        // Non-overlap: only bit 5 hits.
        do_cfg(8'b10010, 4'd5, 1'b0, 8'd0, 1'b0);
        pulse_start();
        stream(8'b10010010, 8, 8'b00001000, 0, 0);
        idle();
        check("novl_cnt", 32'(match_cnt), 32'd1);
        pulse_abort();

        // Target 2: DONE after bit 8, further bits ignored.
        do_cfg(8'b10010, 4'd5, 1'b1, 8'd2, 1'b0);
        pulse_start();
        stream(8'b10010010, 8, 8'b00001001, 0, 2);
        check("tgt_done", 32'(done), 32'd1);
        check("tgt_busy", 32'(busy), 32'd0);
        stream(8'b00100100, 6, 8'b00000000, 0, 0);
        idle();
        check("tgt_cnt_hold", 32'(match_cnt), 32'd2);
        check("tgt_ready", 32'(cfg_ready), 32'd1);
        do_cfg(8'b10010, 4'd5, 1'b1, 8'd0, 1'b0);
        check("tgt_done_clr", 32'(done), 32'd0);

        // Handshake in RUN: held config is refused, old pattern still in force.
        pulse_start();
        cfg_valid = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1;
        cfg_target = 8'd0;
        cycle();
        check("run_ready", 32'(cfg_ready), 32'd0);
        stream(8'b10010, 5, 8'b00001, 0, 0);
        idle();
        pulse_abort();
        check("abort_ready", 32'(cfg_ready), 32'd1);
        check("abort_cnt", 32'(match_cnt), 32'd1);
        cycle();
        cfg_valid = 1'b0;
        pulse_start();
        stream(8'b101, 3, 8'b101, 0, 0);
        idle();
        check("newcfg_cnt", 32'(match_cnt), 32'd2);
        pulse_abort();

        // Clamp: len 0 acts as 1, every 1 bit hits even without overlap.
        do_cfg(8'h01, 4'd0, 1'b0, 8'd0, 1'b0);
        pulse_start();
        stream(8'b1101, 4, 8'b1101, 0, 0);
        idle();
        check("len0_cnt", 32'(match_cnt), 32'd3);
        pulse_abort();

        // Clamp: len 15 acts as 8.
        do_cfg(8'hA5, 4'd15, 1'b1, 8'd0, 1'b0);
        pulse_start();
        stream(8'hA5, 8, 8'h01, 0, 0);
        idle();
        pulse_abort();

        // start+abort from IDLE stays IDLE, so a 1 bit does not hit.
        do_cfg(8'h01, 4'd1, 1'b1, 8'd0, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        stream(8'b1, 1, 8'b0, 0, 0);
        idle();
        check("sa_cnt", 32'(match_cnt), 32'd1);

        // start+config together: new len-2 pattern governs the first bit.
        do_cfg(8'h03, 4'd2, 1'b1, 8'd0, 1'b1);
        check("sc_busy", 32'(busy), 32'd1);
        stream(8'b11, 2, 8'b01, 0, 0);
        idle();
        pulse_abort();

        // Asynchronous reset between edges mid-run.
        do_cfg(8'b10010, 4'd5, 1'b1, 8'd0, 1'b1);
        stream(8'b1001001, 7, 8'b0000100, 0, 0);
        x_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_hit", 32'(hit), 32'd0);
        check("arst_cnt", 32'(match_cnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        cycle();
        rst = 1'b0;
        check("arst_ready", 32'(cfg_ready), 32'd1);
        do_cfg(8'b10010, 4'd5, 1'b1, 8'd0, 1'b1);
        stream(8'b10010, 5, 8'b00001, 0, 0);
        idle();
        check("arst_post_cnt", 32'(match_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
